// File: rtl/alu_pipelined.sv
// Handshaked ALU: single-cycle logic/add/sub, iterative WIDTH-step shift-add multiply.
// One result register sits between issue (in_*) and writeback (out_*).
module alu_pipelined #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic [2:0]       out_op,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and ready may depend combinationally on out_ready.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mul_b;
  logic [CW-1:0]      mul_cnt;
  logic               accept;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               alu_err;

  assign in_ready  = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == HOLD);
  assign dbg_state = state;

  // Single-cycle datapath; the top bit of the widened subtract is the borrow.
  always_comb begin
    add_sum    = {1'b0, in_a} + {1'b0, in_b};
    sub_diff   = {1'b0, in_a} - {1'b0, in_b};
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_err    = 1'b0;
    case (in_op)
      OP_AND: alu_result = in_a & in_b;
      OP_OR:  alu_result = in_a | in_b;
      OP_XOR: alu_result = in_a ^ in_b;
      OP_ADD: {alu_carry, alu_result} = add_sum;
      OP_SUB: begin
        alu_result = sub_diff[WIDTH-1:0];
        alu_carry  = sub_diff[WIDTH];
      end
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_step = mul_b[0] ? (acc + mul_a) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mul_a      <= '0;
      mul_b      <= '0;
      acc        <= '0;
      mul_cnt    <= '0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
      out_op     <= 3'b000;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (in_op == OP_MUL) begin
              state   <= BUSY;
              mul_a   <= {{WIDTH{1'b0}}, in_a};
              mul_b   <= in_b;
              acc     <= '0;
              mul_cnt <= '0;
            end else begin
              state      <= HOLD;
              out_result <= alu_result;
              out_carry  <= alu_carry;
              out_zero   <= (alu_result == '0);
              out_err    <= alu_err;
              out_op     <= in_op;
            end
          end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc     <= acc_step;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + CW'(1);
          // Last partial product folds in on this edge, so publish acc_step directly.
          if (mul_cnt == CW'(WIDTH-1)) begin
            state      <= HOLD;
            out_result <= acc_step[WIDTH-1:0];
            out_carry  <= |acc_step[2*WIDTH-1:WIDTH];
            out_zero   <= (acc_step[WIDTH-1:0] == '0);
            out_err    <= 1'b0;
            out_op     <= OP_MUL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipelined.sv
// Bench for alu_pipelined: directed scenarios plus randomized traffic, checked
// against an arithmetic reference model and an expected-result queue.
module tb_alu_pipelined;

  localparam int W  = 8;
  localparam int EW = W + 6;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;
  logic         out_err;
  logic [2:0]   out_op;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  int            m_busy    = 0;
  bit            m_pending = 0;

  alu_pipelined #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .out_op     (out_op),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic modulo 2^W.
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int unsigned ua, ub, full, r;
    bit c, e;
    ua = a; ub = b; full = 1 << W; r = 0; c = 0; e = 0;
    case (op)
      3'b001: r = ua & ub;
      3'b010: r = ua | ub;
      3'b011: r = ua ^ ub;
      3'b101: begin r = (ua + ub) % full; c = (ua + ub) >= full; end
      3'b110: begin r = (ua + full - ub) % full; c = ua < ub; end
      3'b111: begin r = (ua * ub) % full; c = (ua * ub) >= full; end
      default: e = 1;
    endcase
    return {op, e, (r == 0), c, r[W-1:0]};
  endfunction

  function automatic logic [EW-1:0] pack_out();
    return {out_op, out_err, out_zero, out_carry, out_result};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge with inputs set; checks, advances one edge, updates model.
  task automatic cycle(output bit accepted);
    bit   cons;
    logic exp_ready;
    #1;
    exp_ready = rst_n && (m_busy == 0) && (!m_pending || out_ready);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_pending);
    if (m_pending && exp_q.size() > 0) check("result_pack", pack_out(), exp_q[0]);
    accepted = in_valid && exp_ready;
    cons     = m_pending && out_ready;
    @(posedge clk);
    if (cons) begin
      void'(exp_q.pop_front());
      m_pending = 0;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_pending = 1;
    end
    if (accepted) begin
      exp_q.push_back(model(in_op, in_a, in_b));
      if (in_op == 3'b111) m_busy = W;
      else m_pending = 1;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    bit acc;
    cycle(acc);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int guard;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    acc = 0; guard = 0;
    while (!acc && guard < 50) begin
      cycle(acc);
      guard++;
    end
    if (!acc) check("accept_timeout", 32'(guard), 32'd0);
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; in_valid = 1'b0;
    exp_q.delete(); m_busy = 0; m_pending = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", pack_out(), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = '0; in_b = '0; out_ready = 1'b1;
    @(negedge clk);
    do_reset(3);

    // ADD with carry-out
    issue(3'b101, 8'hF0, 8'h20);
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 8'h10);
    check("add_carry", out_carry, 1);
    check("add_zero", out_zero, 0);
    check("add_op", out_op, 3'b101);
    tick();

    // SUB with borrow, then SUB to zero
    issue(3'b110, 8'h05, 8'h07);
    check("sub_result", out_result, 8'hFE);
    check("sub_borrow", out_carry, 1);
    issue(3'b110, 8'h07, 8'h07);
    check("sub0_result", out_result, 8'h00);
    check("sub0_zero", out_zero, 1);
    check("sub0_carry", out_carry, 0);
    tick();

    // MUL latency and busy back-pressure
    issue(3'b111, 8'h0F, 8'h11);
    for (int e = 0; e < W; e++) begin
      check("mul_busy_valid", out_valid, 0);
      check("mul_busy_ready", in_ready, 0);
      in_a = W'($urandom); in_b = W'($urandom);
      tick();
    end
    check("mul_valid", out_valid, 1);
    check("mul_result", out_result, 8'hFF);
    check("mul_carry", out_carry, 0);
    tick();
    issue(3'b111, 8'h10, 8'h10);
    for (int e = 0; e < W; e++) tick();
    check("mul_hi_result", out_result, 8'h00);
    check("mul_hi_carry", out_carry, 1);
    check("mul_hi_zero", out_zero, 1);
    tick();

    // Streaming XORs, then downstream stall and release
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_op = 3'b011; in_a = W'($urandom); in_b = W'($urandom);
      tick();
      check("stream_valid", out_valid, 1);
    end
    in_a = W'($urandom); in_b = W'($urandom);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();

    // Reserved opcode
    issue(3'b100, 8'hFF, 8'hFF);
    check("rsv_result", out_result, 8'h00);
    check("rsv_err", out_err, 1);
    check("rsv_zero", out_zero, 1);
    check("rsv_carry", out_carry, 0);
    tick();

    // Reset mid-MUL aborts the operation
    issue(3'b111, 8'hAB, 8'hCD);
    for (int i = 0; i < 4; i++) tick();
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      check("no_stale", out_valid, 0);
      tick();
    end
    issue(3'b001, 8'h3C, 8'h0F);
    check("and_result", out_result, 8'h0C);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (m_pending || m_busy > 0); i++) tick();
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
